mutex_merge_arb_fifo: RTL

- Clocked, parametrised N-to-1 merge for the cache control path.
- Arbitrates between NUM_CH drive/free request channels and captures the winning channel's data into an integrated output FIFO.
- Presents the FIFO head to the downstream consumer with a drive/free handshake.
- Replaces the fixed 4-channel, 38-bit merge-plus-external-FIFO arrangement; adds selectable fixed or round-robin priority and full backpressure.

---
 rtl/mutex_merge_arb_fifo.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mutex_merge_arb_fifo.sv
// N-to-1 request merge with fixed or round-robin arbitration feeding an integrated FIFO.
// Optional macro MERGE_SRC_ID_EN stores the granted channel index per entry and exposes it on o_src.
module mutex_merge_arb_fifo #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 38,
  parameter int DEPTH   = 4,
  parameter int RR_MODE = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_CH-1:0]          i_drive,
  input  logic [NUM_CH*DATA_W-1:0]   i_data,
  output logic [NUM_CH-1:0]          o_free,
  output logic                       o_driveNext,
  output logic [DATA_W-1:0]          o_data,
  input  logic                       i_freeNext
`ifdef MERGE_SRC_ID_EN
  ,
  output logic [$clog2(NUM_CH)-1:0]  o_src
`endif
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic [DATA_W-1:0] mem [DEPTH];

  logic [CNT_W-1:0] count_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CH_W-1:0]  rr_ptr_reg;

  logic [NUM_CH-1:0] grant_vec;
  logic [CH_W-1:0]   grant_idx;
  logic [CH_W:0]     search_sum;
  logic [CH_W-1:0]   search_idx;
  logic              found;
  logic              can_push;
  logic              push;
  logic              pop;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign ch_data[gi] = i_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // A pop in the same cycle never opens a slot, keeping o_free independent of i_freeNext.
  assign can_push = (count_reg < CNT_W'(DEPTH)) && !i_rst;

  always_comb begin
    grant_vec  = '0;
    grant_idx  = '0;
    found      = 1'b0;
    search_sum = '0;
    search_idx = '0;
    if (can_push) begin
      for (int off = 0; off < NUM_CH; off++) begin
        if (RR_MODE != 0) begin
          search_sum = {1'b0, rr_ptr_reg} + (CH_W+1)'(off);
          if (search_sum >= (CH_W+1)'(NUM_CH)) begin
            search_sum = search_sum - (CH_W+1)'(NUM_CH);
          end
          search_idx = search_sum[CH_W-1:0];
        end else begin
          search_idx = CH_W'(off);
        end
        if (!found && i_drive[search_idx]) begin
          found                 = 1'b1;
          grant_vec[search_idx] = 1'b1;
          grant_idx             = search_idx;
        end
      end
    end
  end

  assign o_free = grant_vec;
  assign push   = found;
  assign pop    = (count_reg != '0) && i_freeNext;

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= ch_data[grant_idx];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      rr_ptr_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        rr_ptr_reg <= (grant_idx == CH_W'(NUM_CH-1)) ? '0 : grant_idx + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Head is read straight from storage so a grant is visible the very next cycle.
  assign o_driveNext = (count_reg != '0);
  assign o_data      = o_driveNext ? mem[rd_ptr_reg] : '0;

`ifdef MERGE_SRC_ID_EN
  logic [CH_W-1:0] src_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (push) begin
      src_mem[wr_ptr_reg] <= grant_idx;
    end
  end

  assign o_src = o_driveNext ? src_mem[rd_ptr_reg] : '0;
`endif

endmodule
